// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types for the round-robin mux controller: FSM encoding and requester index.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package mux_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    typedef logic [1:0] req_idx_t;

    // One-hot vector with bit idx set; used for grant vectors and "other requester" masks.
    function automatic logic [NUM_REQ-1:0] idx_onehot(input req_idx_t idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// Gate-level 4:1 one-bit multiplexer; addr1 is the select MSB, addr0 the LSB.
// Latency: purely combinational.
// Backpressure: none; the output follows inputs and selects directly.
module structuralMultiplexer (
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic addr0,
    input  logic addr1,
    output wire  out
);

    wire n_addr0;
    wire n_addr1;
    wire t0;
    wire t1;
    wire t2;
    wire t3;

    not g_n0 (n_addr0, addr0);
    not g_n1 (n_addr1, addr1);

    and g_a0 (t0, in0, n_addr1, n_addr0);
    and g_a1 (t1, in1, n_addr1, addr0);
    and g_a2 (t2, in2, addr1,   n_addr0);
    and g_a3 (t3, in3, addr1,   addr0);

    or  g_o  (out, t0, t1, t2, t3);

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of the shared 4:1 mux: pick a requester, settle the select, stream its bits.
// Latency: grant 1 + SETTLE cycles after pick; each beat appears on out_* one cycle after it is taken.
// Backpressure: out_ready low in GRANT stalls the beat, freezes the hold count and keeps the grant.
import mux_rr_arbiter_pkg::*;

module mux_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int SETTLE   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] din,
    input  logic               out_ready,
    output logic [NUM_REQ-1:0] gnt,
    output logic               addr0,
    output logic               addr1,
    output logic               out_valid,
    output logic               out_data,
    output req_idx_t           out_src
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(MAX_HOLD - 1);
    localparam logic [1:0]        SETTLE_LAST = 2'((SETTLE > 0) ? (SETTLE - 1) : 0);

    state_t            state;
    req_idx_t          ptr;
    req_idx_t          sel;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        settle_cnt;

    logic              mux_out;
    logic              beat;
    logic              others_pending;
    req_idx_t          winner;

    // First set request scanning ptr, ptr+1, ... (mod 4). Result is only used when |r.
    function automatic req_idx_t rr_pick(input logic [NUM_REQ-1:0] r, input req_idx_t p);
        req_idx_t idx;
        req_idx_t pick;
        pick = p;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = p + req_idx_t'(i);
            if (r[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    // Select lines come straight from the sel register so they stay put through SETUP and GRANT.
    assign addr0 = sel[0];
    assign addr1 = sel[1];

    structuralMultiplexer u_mux (
        .in0   (din[0]),
        .in1   (din[1]),
        .in2   (din[2]),
        .in3   (din[3]),
        .addr0 (addr0),
        .addr1 (addr1),
        .out   (mux_out)
    );

    // Beat qualification and fairness inputs for the FSM.
    always_comb begin
        beat           = (state == ST_GRANT) && req[sel] && out_ready;
        others_pending = |(req & ~idx_onehot(sel));
        winner         = rr_pick(req, ptr);
    end

    // Arbitration FSM: pick, settle the select path, then hold the grant up to MAX_HOLD beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            sel        <= '0;
            hold_cnt   <= '0;
            settle_cnt <= '0;
            gnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    gnt <= '0;
                    if (|req) begin
                        sel        <= winner;
                        settle_cnt <= '0;
                        hold_cnt   <= '0;
                        if (SETTLE == 0) begin
                            state <= ST_GRANT;
                            gnt   <= idx_onehot(winner);
                        end else begin
                            state <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    // req[sel] may drop here; the grant is still issued and released in GRANT.
                    gnt <= '0;
                    if (settle_cnt == SETTLE_LAST) begin
                        state      <= ST_GRANT;
                        settle_cnt <= '0;
                        gnt        <= idx_onehot(sel);
                    end else begin
                        settle_cnt <= settle_cnt + 2'd1;
                    end
                end
                ST_GRANT: begin
                    if (!req[sel]) begin
                        state    <= ST_IDLE;
                        ptr      <= sel + 2'd1;
                        hold_cnt <= '0;
                        gnt      <= '0;
                    end else if (beat) begin
                        if (hold_cnt == HOLD_LAST) begin
                            if (others_pending) begin
                                state    <= ST_IDLE;
                                ptr      <= sel + 2'd1;
                                hold_cnt <= '0;
                                gnt      <= '0;
                            end else begin
                                // Nobody else waiting: restart the hold window, keep the grant.
                                hold_cnt <= '0;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    // Registered output stage: capture the mux output and source index on each beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= 1'b0;
            out_src   <= '0;
        end else begin
            out_valid <= beat;
            if (beat) begin
                out_data <= mux_out;
                out_src  <= sel;
            end
        end
    end

endmodule
